// File: rtl/digit_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | digit_entry: builds a 32-bit operand from keyed digits in radix 1..16    |
// |              and offers it to the processor over a valid/ready handshake.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module digit_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  radix_sel,
  input  logic [3:0]  digit,
  input  logic        btn_enter,
  input  logic        btn_commit,
  input  logic        btn_clear,
  input  logic        data_ready,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [31:0] entry_value,
  output logic [5:0]  digit_count,
  output logic        overflow,
  output logic        bad_digit
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_PENDING = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_enter_q;
  logic        r_commit_q;
  logic        r_clear_q;
  logic [31:0] r_acc;
  logic [31:0] w_acc_nxt;
  logic [31:0] r_data;
  logic [31:0] w_data_nxt;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_nxt;
  logic        r_ovf;
  logic        w_ovf_nxt;
  logic        r_bad;
  logic        w_bad_nxt;
  logic        r_valid;
  logic        w_valid_nxt;

  logic        w_enter_p;
  logic        w_commit_p;
  logic        w_clear_p;
  logic [4:0]  w_radix;
  logic [36:0] w_next;
  logic        w_digit_ok;
  logic        w_xfer;

  assign w_enter_p  = btn_enter  & ~r_enter_q;
  assign w_commit_p = btn_commit & ~r_commit_q;
  assign w_clear_p  = btn_clear  & ~r_clear_q;

  assign w_radix    = {1'b0, radix_sel} + 5'd1;
  assign w_digit_ok = ({1'b0, digit} < w_radix);
  // 37 bits hold the worst case (2^32-1)*16+15 exactly, so any high bit means overflow
  assign w_next     = ({5'd0, r_acc} * {32'd0, w_radix}) + {33'd0, digit};
  assign w_xfer     = r_valid & data_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_enter_q  <= 1'b1;
      r_commit_q <= 1'b1;
      r_clear_q  <= 1'b1;
      r_acc      <= 32'd0;
      r_data     <= 32'd0;
      r_cnt      <= 6'd0;
      r_ovf      <= 1'b0;
      r_bad      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_enter_q  <= btn_enter;
      r_commit_q <= btn_commit;
      r_clear_q  <= btn_clear;
      r_acc      <= w_acc_nxt;
      r_data     <= w_data_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_bad      <= w_bad_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_bad_nxt   = 1'b0;
    w_valid_nxt = r_valid;

    case (r_state)
      S_PENDING: begin
        // Handshake and clear both end in IDLE; a coincident handshake still delivers the word
        if (w_xfer || w_clear_p) begin
          w_valid_nxt = 1'b0;
          w_acc_nxt   = 32'd0;
          w_cnt_nxt   = 6'd0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        if (w_clear_p) begin
          w_acc_nxt   = 32'd0;
          w_cnt_nxt   = 6'd0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_commit_p) begin
          if (r_state == S_ENTRY) begin
            w_data_nxt  = r_acc;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_PENDING;
          end
        end else if (w_enter_p) begin
          if (!w_digit_ok) begin
            w_bad_nxt = 1'b1;
          end else if (w_next[36:32] != 5'd0) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_acc_nxt   = w_next[31:0];
            w_cnt_nxt   = (r_cnt == 6'd32) ? r_cnt : r_cnt + 6'd1;
            w_state_nxt = S_ENTRY;
          end
        end
      end
    endcase
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign entry_value = r_acc;
  assign digit_count = r_cnt;
  assign overflow    = r_ovf;
  assign bad_digit   = r_bad;

endmodule
`default_nettype wire
